// File: rtl/sd_cmd_responder_pkg.sv
// Shared definitions for the card-side SD CMD responder: frame geometry,
// CRC7 polynomial, transmission-bit values, FSM encodings and the CRC7 step.
package sd_cmd_responder_pkg;

   localparam int         FRAME_LEN = 48;
   localparam int         CRC_POS   = 40;
   localparam logic [6:0] CRC7_POLY = 7'h09;
   localparam logic       TX_HOST   = 1'b1;
   localparam logic       TX_CARD   = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_CHECK = 3'd2,
      ST_WAIT  = 3'd3,
      ST_SEND  = 3'd4
   } state_t;

   // One serial CRC7 step, MSB-first data, x^7 + x^3 + 1.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic data);
      logic fb;
      fb = data ^ crc[6];
      crc7_step = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_cmd_responder_crc7_serial.sv
// Bit-serial CRC7 accumulator. Clear restarts from zero; if enable is also
// high on that edge the data bit is folded into the fresh register.
module crc7_serial
   import sd_cmd_responder_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       enable,
   input  logic       data,
   output logic [6:0] crc
);

   logic [6:0] crc_r;

   // CRC register update
   always_ff @(posedge clk) begin
      if (reset) begin
         crc_r <= 7'h00;
      end else if (clear) begin
         crc_r <= enable ? crc7_step(7'h00, data) : 7'h00;
      end else if (enable) begin
         crc_r <= crc7_step(crc_r, data);
      end else begin
         crc_r <= crc_r;
      end
   end

   assign crc = crc_r;

endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line: receives and checks 48-bit host commands, then
// answers after an NCR gap with a 48-bit response carrying a fresh CRC7.
module sd_cmd_responder
   import sd_cmd_responder_pkg::*;
#(
   parameter int NCR = 2
)(
   input  logic        sd_clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        cmd_in,
   input  logic        resp_enable,
   input  logic [31:0] resp_arg,
   output logic        cmd_out,
   output logic        cmd_oe,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_arg,
   output logic        cmd_valid,
   output logic        frame_error,
   output logic        busy
);

   state_t      state_r;
   logic [5:0]  bit_cnt_r;
   logic [6:0]  ncr_cnt_r;
   logic [46:0] rx_shift_r;
   logic [39:0] tx_shift_r;
   logic        cmd_out_r;
   logic        cmd_oe_r;
   logic [5:0]  cmd_index_r;
   logic [31:0] cmd_arg_r;
   logic        cmd_valid_r;
   logic        frame_error_r;
   logic        busy_r;

   logic [47:0] rx_frame_s;
   logic        good_frame_s;
   logic [6:0]  rx_crc_s;
   logic [6:0]  tx_crc_s;
   logic        rx_crc_clr_s;
   logic        rx_crc_en_s;
   logic        tx_crc_clr_s;
   logic        tx_crc_en_s;
   logic        tx_bit_s;

   // The end bit is judged live on the edge that samples it, so the verdict
   // pulses are visible during the CHECK cycle itself.
   assign rx_frame_s   = {rx_shift_r, cmd_in};
   assign good_frame_s = (rx_frame_s[47] == 1'b0) && (rx_frame_s[46] == TX_HOST) &&
                         (rx_frame_s[0] == 1'b1) && (rx_crc_s == rx_frame_s[7:1]);

   crc7_serial u_rx_crc (
      .clk    (sd_clock),
      .reset  (reset),
      .clear  (rx_crc_clr_s),
      .enable (rx_crc_en_s),
      .data   (cmd_in),
      .crc    (rx_crc_s)
   );

   crc7_serial u_tx_crc (
      .clk    (sd_clock),
      .reset  (reset),
      .clear  (tx_crc_clr_s),
      .enable (tx_crc_en_s),
      .data   (tx_shift_r[39]),
      .crc    (tx_crc_s)
   );

   // CRC sequencing for both paths and selection of the next response bit
   always_comb begin
      rx_crc_clr_s = (state_r == ST_IDLE);
      tx_crc_clr_s = (state_r != ST_SEND);
      rx_crc_en_s  = 1'b0;
      tx_crc_en_s  = 1'b0;
      tx_bit_s     = 1'b1;
      if (state_r == ST_IDLE) begin
         rx_crc_en_s = 1'b1;
      end else if (state_r == ST_RECV) begin
         rx_crc_en_s = (bit_cnt_r < 6'(CRC_POS));
      end else begin
         rx_crc_en_s = 1'b0;
      end
      if (state_r == ST_WAIT) begin
         tx_crc_en_s = (ncr_cnt_r == 7'(NCR));
      end else if (state_r == ST_SEND) begin
         tx_crc_en_s = (bit_cnt_r < 6'(CRC_POS));
      end else begin
         tx_crc_en_s = 1'b0;
      end
      // CRC field starts at bit 40, a multiple of 8, so the low counter bits index it
      if (bit_cnt_r < 6'(CRC_POS)) begin
         tx_bit_s = tx_shift_r[39];
      end else if (bit_cnt_r < 6'(FRAME_LEN - 1)) begin
         tx_bit_s = tx_crc_s[3'd6 - bit_cnt_r[2:0]];
      end else begin
         tx_bit_s = 1'b1;
      end
   end

   // Command/response state machine with registered outputs
   always_ff @(posedge sd_clock) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         bit_cnt_r     <= 6'd0;
         ncr_cnt_r     <= 7'd0;
         rx_shift_r    <= 47'h0;
         tx_shift_r    <= 40'h0;
         cmd_out_r     <= 1'b1;
         cmd_oe_r      <= 1'b0;
         cmd_index_r   <= 6'd0;
         cmd_arg_r     <= 32'h0;
         cmd_valid_r   <= 1'b0;
         frame_error_r <= 1'b0;
         busy_r        <= 1'b0;
      end else if (!enable) begin
         state_r       <= ST_IDLE;
         bit_cnt_r     <= 6'd0;
         ncr_cnt_r     <= 7'd0;
         cmd_out_r     <= 1'b1;
         cmd_oe_r      <= 1'b0;
         cmd_valid_r   <= 1'b0;
         frame_error_r <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         cmd_valid_r   <= 1'b0;
         frame_error_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (!cmd_in) begin
                  state_r    <= ST_RECV;
                  bit_cnt_r  <= 6'd1;
                  rx_shift_r <= {46'h0, cmd_in};
                  busy_r     <= 1'b1;
               end else begin
                  busy_r     <= 1'b0;
               end
            end
            ST_RECV: begin
               rx_shift_r <= {rx_shift_r[45:0], cmd_in};
               bit_cnt_r  <= bit_cnt_r + 6'd1;
               if (bit_cnt_r == 6'(FRAME_LEN - 1)) begin
                  state_r <= ST_CHECK;
                  if (good_frame_s) begin
                     cmd_valid_r <= 1'b1;
                     cmd_index_r <= rx_frame_s[45:40];
                     cmd_arg_r   <= rx_frame_s[39:8];
                  end else begin
                     frame_error_r <= 1'b1;
                  end
               end else begin
                  state_r <= ST_RECV;
               end
            end
            ST_CHECK: begin
               if (cmd_valid_r && resp_enable) begin
                  state_r    <= ST_WAIT;
                  ncr_cnt_r  <= 7'd0;
                  tx_shift_r <= {1'b0, TX_CARD, cmd_index_r, resp_arg};
               end else begin
                  state_r    <= ST_IDLE;
                  busy_r     <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (ncr_cnt_r == 7'(NCR)) begin
                  state_r    <= ST_SEND;
                  cmd_oe_r   <= 1'b1;
                  cmd_out_r  <= tx_shift_r[39];
                  tx_shift_r <= {tx_shift_r[38:0], 1'b0};
                  bit_cnt_r  <= 6'd1;
               end else begin
                  ncr_cnt_r  <= ncr_cnt_r + 7'd1;
               end
            end
            ST_SEND: begin
               if (bit_cnt_r == 6'(FRAME_LEN)) begin
                  state_r   <= ST_IDLE;
                  cmd_oe_r  <= 1'b0;
                  cmd_out_r <= 1'b1;
                  busy_r    <= 1'b0;
                  bit_cnt_r <= 6'd0;
               end else begin
                  cmd_out_r <= tx_bit_s;
                  bit_cnt_r <= bit_cnt_r + 6'd1;
                  if (bit_cnt_r < 6'(CRC_POS)) begin
                     tx_shift_r <= {tx_shift_r[38:0], 1'b0};
                  end else begin
                     tx_shift_r <= tx_shift_r;
                  end
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               cmd_oe_r  <= 1'b0;
               cmd_out_r <= 1'b1;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_out     = cmd_out_r;
   assign cmd_oe      = cmd_oe_r;
   assign cmd_index   = cmd_index_r;
   assign cmd_arg     = cmd_arg_r;
   assign cmd_valid   = cmd_valid_r;
   assign frame_error = frame_error_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Scoreboard bench for sd_cmd_responder: expected verdicts and response frames
// are queued as commands are driven and matched as the DUT produces them.
module tb_sd_cmd_responder;

   localparam int NCR = 2;

   logic        sd_clock = 1'b0;
   logic        reset, enable, cmd_in, resp_enable;
   logic [31:0] resp_arg;
   logic        cmd_out, cmd_oe, cmd_valid, frame_error, busy;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;

   sd_cmd_responder #(.NCR(NCR)) dut (
      .sd_clock    (sd_clock),
      .reset       (reset),
      .enable      (enable),
      .cmd_in      (cmd_in),
      .resp_enable (resp_enable),
      .resp_arg    (resp_arg),
      .cmd_out     (cmd_out),
      .cmd_oe      (cmd_oe),
      .cmd_index   (cmd_index),
      .cmd_arg     (cmd_arg),
      .cmd_valid   (cmd_valid),
      .frame_error (frame_error),
      .busy        (busy)
   );

   always #5 sd_clock = ~sd_clock;

   typedef struct {
      logic        is_err;
      logic [5:0]  idx;
      logic [31:0] arg;
   } ev_t;

   ev_t         ev_q[$];
   logic [47:0] rsp_q[$];
   int          err_cnt = 0;
   int          chk_cnt = 0;
   int          cyc = 0;
   logic        ignore_rsp = 1'b0;
   logic [5:0]  held_idx;
   logic [31:0] held_arg;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [6:0] crc7_of(input logic [39:0] bits);
      logic [6:0] c;
      c = 7'h00;
      for (int i = 39; i >= 0; i--) begin
         if (bits[i] ^ c[6]) c = {c[5:0], 1'b0} ^ 7'h09;
         else                c = {c[5:0], 1'b0};
      end
      return c;
   endfunction

   function automatic logic [47:0] mk_frame(input logic trans, input logic [5:0] idx,
                                            input logic [31:0] arg, input logic end_bit);
      logic [39:0] head;
      head = {1'b0, trans, idx, arg};
      return {head, crc7_of(head), end_bit};
   endfunction

   task automatic send_cmd(input logic [47:0] f);
      for (int i = 47; i >= 0; i--) begin
         cmd_in = f[i];
         @(negedge sd_clock);
      end
      cmd_in = 1'b1;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 300) begin
         @(negedge sd_clock);
         n++;
      end
      check_val(tag, busy, 1'b0);
   endtask

   task automatic wait_oe(input logic level, input string tag);
      int n;
      n = 0;
      while (cmd_oe !== level && n < 300) begin
         @(negedge sd_clock);
         n++;
      end
      check_val(tag, cmd_oe, level);
   endtask

   task automatic push_good(input logic [5:0] idx, input logic [31:0] arg);
      ev_t e;
      e.is_err = 1'b0; e.idx = idx; e.arg = arg;
      ev_q.push_back(e);
   endtask

   task automatic push_err();
      ev_t e;
      e.is_err = 1'b1; e.idx = 6'd0; e.arg = 32'h0;
      ev_q.push_back(e);
   endtask

   initial forever begin
      @(posedge sd_clock);
      cyc++;
   end

   // Monitor: verdict pulses, response timing and response frames
   initial begin
      logic        prev_oe, prev_pulse;
      logic [47:0] rsp_bits;
      int          rsp_n, valid_cyc;
      ev_t         e;
      prev_oe = 1'b0; prev_pulse = 1'b0; rsp_bits = 48'h0; rsp_n = 0; valid_cyc = 0;
      forever begin
         @(negedge sd_clock);
         if (cmd_valid === 1'b1 || frame_error === 1'b1) begin
            check_val("pulse_width", prev_pulse, 1'b0);
            if (cmd_valid === 1'b1) valid_cyc = cyc;
            if (ev_q.size() == 0) begin
               check_val("unexpected_event", 1'b1, 1'b0);
            end else begin
               e = ev_q.pop_front();
               check_val("event_kind", {cmd_valid, frame_error}, {~e.is_err, e.is_err});
               if (!e.is_err) begin
                  check_val("cmd_index", cmd_index, e.idx);
                  check_val("cmd_arg", cmd_arg, e.arg);
               end
            end
         end
         if (cmd_oe === 1'b1) begin
            if (!prev_oe) check_val("oe_latency", cyc - valid_cyc, NCR + 2);
            rsp_bits = {rsp_bits[46:0], cmd_out};
            rsp_n++;
         end else if (prev_oe) begin
            check_val("released_out_high", cmd_out, 1'b1);
            if (ignore_rsp) begin
               ignore_rsp = 1'b0;
            end else if (rsp_q.size() == 0) begin
               check_val("unexpected_response", 1'b1, 1'b0);
            end else begin
               check_val("rsp_len", rsp_n, 48);
               check_val("rsp_frame", rsp_bits, rsp_q.pop_front());
            end
            rsp_n = 0;
         end
         prev_oe    = (cmd_oe === 1'b1);
         prev_pulse = (cmd_valid === 1'b1) || (frame_error === 1'b1);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", err_cnt);
      $fatal(1);
   end

   initial begin
      logic [47:0] f, f2;
      logic [5:0]  idx;
      logic [31:0] arg;
      reset = 1'b1; enable = 1'b1; cmd_in = 1'b1; resp_enable = 1'b0; resp_arg = 32'h0;
      repeat (3) @(negedge sd_clock);
      check_val("rst_cmd_out", cmd_out, 1'b1);
      check_val("rst_cmd_oe", cmd_oe, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_pulses", {cmd_valid, frame_error}, 2'b00);
      check_val("rst_held", {cmd_index, cmd_arg}, 38'h0);
      reset = 1'b0;
      @(negedge sd_clock);

      // CMD0, no response
      resp_enable = 1'b0;
      push_good(6'd0, 32'h0);
      send_cmd(48'h40_0000_0000_95);
      wait_idle("cmd0_idle");
      repeat (4) @(negedge sd_clock);
      check_val("cmd0_no_oe", cmd_oe, 1'b0);

      // CMD17 with R1 response
      resp_enable = 1'b1; resp_arg = 32'h0000_0900;
      push_good(6'd17, 32'h0);
      rsp_q.push_back(48'h11_0000_0900_67);
      send_cmd(48'h51_0000_0000_55);
      wait_idle("cmd17_idle");
      check_val("cmd17_index", cmd_index, 6'd17);

      // Random good commands, response optional
      for (int k = 0; k < 3; k++) begin
         idx = 6'($urandom_range(0, 63));
         arg = $urandom;
         resp_enable = 1'($urandom_range(0, 1));
         resp_arg = $urandom;
         push_good(idx, arg);
         if (resp_enable) rsp_q.push_back(mk_frame(1'b0, idx, resp_arg, 1'b1));
         send_cmd(mk_frame(1'b1, idx, arg, 1'b1));
         wait_idle("rand_idle");
         held_idx = idx; held_arg = arg;
      end

      // Error frames: CRC, transmission bit, end bit; response requested but not expected
      resp_enable = 1'b1;
      push_err();
      send_cmd({8'h51, 32'h0, 8'h57});
      wait_idle("crc_err_idle");
      push_err();
      send_cmd(mk_frame(1'b0, 6'd17, 32'h1234_5678, 1'b1));
      wait_idle("trans_err_idle");
      push_err();
      send_cmd(mk_frame(1'b1, 6'd17, 32'h0, 1'b0));
      wait_idle("end_err_idle");
      check_val("err_held_index", cmd_index, held_idx);
      check_val("err_held_arg", cmd_arg, held_arg);

      // Reset at bit 20 of a receive
      f = mk_frame(1'b1, 6'd9, 32'hCAFE_F00D, 1'b1);
      for (int i = 47; i > 27; i--) begin
         cmd_in = f[i];
         @(negedge sd_clock);
      end
      reset = 1'b1; cmd_in = 1'b1;
      @(negedge sd_clock);
      check_val("rstabort_idle", {cmd_oe, cmd_out, busy}, 3'b010);
      check_val("rstabort_held", {cmd_index, cmd_arg}, 38'h0);
      reset = 1'b0;
      @(negedge sd_clock);
      check_val("rstabort_no_pulse", {cmd_valid, frame_error}, 2'b00);

      // Enable dropped at response bit 10
      resp_enable = 1'b1; resp_arg = 32'hA5A5_0001;
      push_good(6'd55, 32'h0BAD_BEEF);
      ignore_rsp = 1'b1;
      send_cmd(mk_frame(1'b1, 6'd55, 32'h0BAD_BEEF, 1'b1));
      wait_oe(1'b1, "abort_oe_rise");
      repeat (10) @(negedge sd_clock);
      enable = 1'b0;
      @(negedge sd_clock);
      check_val("enabort_idle", {cmd_oe, cmd_out, busy}, 3'b010);
      check_val("enabort_no_pulse", {cmd_valid, frame_error}, 2'b00);
      enable = 1'b1;
      @(negedge sd_clock);

      // Good frame after aborts, with response
      resp_arg = 32'h0000_0120;
      push_good(6'd8, 32'h0000_01AA);
      rsp_q.push_back(mk_frame(1'b0, 6'd8, 32'h0000_0120, 1'b1));
      send_cmd(mk_frame(1'b1, 6'd8, 32'h0000_01AA, 1'b1));
      wait_idle("post_abort_idle");

      // Back-to-back: second start bit right after the first response end bit
      resp_arg = 32'h1357_9BDF;
      f  = mk_frame(1'b1, 6'd13, 32'h1111_2222, 1'b1);
      f2 = mk_frame(1'b1, 6'd41, 32'h3333_4444, 1'b1);
      push_good(6'd13, 32'h1111_2222);
      rsp_q.push_back(mk_frame(1'b0, 6'd13, 32'h1357_9BDF, 1'b1));
      send_cmd(f);
      wait_oe(1'b1, "b2b_oe_rise");
      wait_oe(1'b0, "b2b_oe_fall");
      push_good(6'd41, 32'h3333_4444);
      rsp_q.push_back(mk_frame(1'b0, 6'd41, 32'h1357_9BDF, 1'b1));
      send_cmd(f2);
      wait_idle("b2b_idle");

      repeat (5) @(negedge sd_clock);
      check_val("events_drained", ev_q.size(), 0);
      check_val("responses_drained", rsp_q.size(), 0);
      check_val("final_oe", cmd_oe, 1'b0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
